// File: rtl/axis_delay_line.sv
// axis_delay_line: AXI-Stream beat delay line with a runtime-selectable delay.
// Each accepted beat is written into a ring buffer. The output reads the entry
// written active_delay beats earlier, so the stream is delayed by a fixed
// number of accepted beats rather than by clock cycles. Valid and ready pass
// straight through.
// Optional feature: define AXIS_DELAY_LINE_TLAST_EN to delay TLAST together
// with the data. Without it, TLAST bypasses the buffer.
module axis_delay_line #(
  parameter int TDATA_WIDTH = 32,
  parameter int MAX_DELAY   = 256,
  parameter int DELAY_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DELAY_W-1:0]     cfg_delay,
  input  logic                   cfg_load,
  input  logic [TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                   S_AXIS_TLAST,
  input  logic                   S_AXIS_TVALID,
  output logic                   S_AXIS_TREADY,
  output logic [TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                   M_AXIS_TLAST,
  output logic                   M_AXIS_TVALID,
  input  logic                   M_AXIS_TREADY,
  output logic [DELAY_W-1:0]     active_delay,
  output logic                   primed
);

  localparam int PTR_W = $clog2(MAX_DELAY);
  localparam logic [DELAY_W-1:0] MAX_D = DELAY_W'(MAX_DELAY);

`ifdef AXIS_DELAY_LINE_TLAST_EN
  localparam int ENTRY_W = TDATA_WIDTH + 1;
`else
  localparam int ENTRY_W = TDATA_WIDTH;
`endif

  typedef enum logic {FILLING = 1'b0, PRIMED = 1'b1} fill_state_e;

  fill_state_e          state, state_nxt;
  logic [DELAY_W-1:0]   fill_cnt, fill_nxt;
  logic [DELAY_W-1:0]   delay_nxt;
  logic [DELAY_W-1:0]   cfg_clamped;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [ENTRY_W-1:0]   mem [MAX_DELAY];
  logic [ENTRY_W-1:0]   wr_entry;
  logic [ENTRY_W-1:0]   rd_entry;
  logic                 accept;

  assign M_AXIS_TVALID = S_AXIS_TVALID;
  assign S_AXIS_TREADY = M_AXIS_TREADY;
  assign accept        = S_AXIS_TVALID & M_AXIS_TREADY;
  assign primed        = (state == PRIMED);

  // Out-of-range requests saturate at the deepest supported delay.
  assign cfg_clamped = (cfg_delay > MAX_D) ? MAX_D : cfg_delay;

`ifdef AXIS_DELAY_LINE_TLAST_EN
  assign wr_entry = {S_AXIS_TLAST, S_AXIS_TDATA};
`else
  assign wr_entry = S_AXIS_TDATA;
`endif

  // Read offset wraps with the pointer; D = MAX_DELAY lands on wr_ptr itself,
  // which is the oldest entry in the ring.
  assign rd_ptr   = wr_ptr - active_delay[PTR_W-1:0];
  assign rd_entry = mem[rd_ptr];

  // Ring buffer storage, written only on accepted beats.
  // NOTE: the buffer is deliberately not reset; every entry is written before
  // it can be read in PRIMED, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_entry;
  end

  // Write pointer advances once per accepted beat; power-of-two depth wraps.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst)         wr_ptr <= '0;
    else if (accept) wr_ptr <= wr_ptr + 1'b1;
  end

  // Fill-state register together with the committed delay and fill counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= PRIMED;
      fill_cnt     <= '0;
      active_delay <= '0;
    end else begin
      state        <= state_nxt;
      fill_cnt     <= fill_nxt;
      active_delay <= delay_nxt;
    end
  end

  // Next-state logic: a commit restarts filling, counting a coincident beat.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    delay_nxt = active_delay;
    if (cfg_load) begin
      delay_nxt = cfg_clamped;
      if (cfg_clamped == '0) begin
        state_nxt = PRIMED;
        fill_nxt  = '0;
      end else if (accept) begin
        fill_nxt  = DELAY_W'(1);
        state_nxt = (cfg_clamped == DELAY_W'(1)) ? PRIMED : FILLING;
      end else begin
        fill_nxt  = '0;
        state_nxt = FILLING;
      end
    end else if (state == FILLING && accept) begin
      fill_nxt = fill_cnt + 1'b1;
      if (fill_nxt == active_delay) state_nxt = PRIMED;
    end
  end

  // Output data: zeros while filling, passthrough at D = 0, else the ring.
  always_comb begin
    M_AXIS_TDATA = '0;
    M_AXIS_TLAST = S_AXIS_TLAST;
`ifdef AXIS_DELAY_LINE_TLAST_EN
    M_AXIS_TLAST = 1'b0;
    if (state == PRIMED) begin
      if (active_delay == '0) begin
        M_AXIS_TDATA = S_AXIS_TDATA;
        M_AXIS_TLAST = S_AXIS_TLAST;
      end else begin
        M_AXIS_TDATA = rd_entry[TDATA_WIDTH-1:0];
        M_AXIS_TLAST = rd_entry[TDATA_WIDTH];
      end
    end
`else
    if (state == PRIMED) begin
      if (active_delay == '0) M_AXIS_TDATA = S_AXIS_TDATA;
      else                    M_AXIS_TDATA = rd_entry;
    end
`endif
  end

endmodule
